// File: rtl/control_pipeline.sv
// Control path for a 5-stage RISC-V style pipeline: decodes the ID-stage opcode,
// detects load-use hazards and carries the control bundle through EX, MEM and WB.
module control_pipeline #(
    parameter int ALU_SEL_W      = 3,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic                  ex_write,
    output logic                  ex_store,
    output logic                  ex_load,
    output logic                  ex_branch,
    output logic [1:0]            ex_a_sel,
    output logic                  ex_b_sel,
    output logic [2:0]            ex_imm_sel,
    output logic [1:0]            ex_npc_sel,
    output logic [ALU_SEL_W-1:0]  ex_alu_sel,
    output logic                  ex_illegal,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_write,
    output logic                  mem_store,
    output logic                  mem_load,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_write,
    output logic                  wb_load,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  flush_if_id
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_LOAD   = 7'b0000011,
        OP_IALU   = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_AUIPC  = 7'b0010111,
        OP_LUI    = 7'b0110111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic                 write;
        logic                 store;
        logic                 load;
        logic                 branch;
        logic [1:0]           a_sel;
        logic                 b_sel;
        logic [2:0]           imm_sel;
        logic [1:0]           npc_sel;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic                 illegal;
    } ctrl_t;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD   = '0;
    localparam logic [ALU_SEL_W-1:0] ALU_FUNCT = ALU_SEL_W'(1);

    ctrl_t                 w_dec;
    logic                  w_rs1_used;
    logic                  w_rs2_used;
    logic                  w_stall;
    logic                  w_bubble;

    ctrl_t                 r_ex;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_mem_write;
    logic                  r_mem_store;
    logic                  r_mem_load;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_write;
    logic                  r_wb_load;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_dec      = '0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (opcode)
            OP_R: begin
                w_dec.write   = 1'b1;
                w_dec.alu_sel = ALU_FUNCT;
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
            end
            OP_LOAD: begin
                w_dec.write   = 1'b1;
                w_dec.load    = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.alu_sel = ALU_ADD;
                w_rs1_used    = 1'b1;
            end
            OP_IALU: begin
                w_dec.write   = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.alu_sel = ALU_FUNCT;
                w_rs1_used    = 1'b1;
            end
            OP_JALR: begin
                w_dec.write   = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.npc_sel = 2'b11;
                w_rs1_used    = 1'b1;
            end
            OP_STORE: begin
                w_dec.store   = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.imm_sel = 3'b001;
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
            end
            OP_BRANCH: begin
                w_dec.branch  = 1'b1;
                w_dec.imm_sel = 3'b010;
                w_dec.npc_sel = 2'b01;
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.write   = 1'b1;
                w_dec.a_sel   = 2'b01;
                w_dec.b_sel   = 1'b1;
                w_dec.imm_sel = 3'b011;
            end
            OP_LUI: begin
                w_dec.write   = 1'b1;
                w_dec.a_sel   = 2'b10;
                w_dec.b_sel   = 1'b1;
                w_dec.imm_sel = 3'b011;
            end
            OP_JAL: begin
                w_dec.write   = 1'b1;
                w_dec.a_sel   = 2'b01;
                w_dec.b_sel   = 1'b1;
                w_dec.imm_sel = 3'b100;
                w_dec.npc_sel = 2'b10;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // x0 is hardwired to zero, so a write to it is dropped here.
        if (id_rd == '0) w_dec.write = 1'b0;
    end

    generate
        if (LOAD_USE_STALL != 0) begin : g_stall
            // A taken branch squashes the dependent instruction, so it wins over the stall.
            assign w_stall = r_ex.load && (r_ex_rd != '0) && !branch_taken &&
                             ((w_rs1_used && (id_rs1 == r_ex_rd)) ||
                              (w_rs2_used && (id_rs2 == r_ex_rd)));
        end else begin : g_no_stall
            assign w_stall = 1'b0;
        end
    endgenerate

    assign w_bubble = w_stall || branch_taken;

    // NOTE: pipeline state uses non-blocking assignments so every stage samples
    // the previous stage's value from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex        <= '0;
            r_ex_rd     <= '0;
            r_mem_write <= 1'b0;
            r_mem_store <= 1'b0;
            r_mem_load  <= 1'b0;
            r_mem_rd    <= '0;
            r_wb_write  <= 1'b0;
            r_wb_load   <= 1'b0;
            r_wb_rd     <= '0;
        end else begin
            r_ex        <= w_bubble ? '0 : w_dec;
            r_ex_rd     <= w_bubble ? '0 : id_rd;
            r_mem_write <= r_ex.write;
            r_mem_store <= r_ex.store;
            r_mem_load  <= r_ex.load;
            r_mem_rd    <= r_ex_rd;
            r_wb_write  <= r_mem_write;
            r_wb_load   <= r_mem_load;
            r_wb_rd     <= r_mem_rd;
        end
    end

    assign ex_write    = r_ex.write;
    assign ex_store    = r_ex.store;
    assign ex_load     = r_ex.load;
    assign ex_branch   = r_ex.branch;
    assign ex_a_sel    = r_ex.a_sel;
    assign ex_b_sel    = r_ex.b_sel;
    assign ex_imm_sel  = r_ex.imm_sel;
    assign ex_npc_sel  = r_ex.npc_sel;
    assign ex_alu_sel  = r_ex.alu_sel;
    assign ex_illegal  = r_ex.illegal;
    assign ex_rd       = r_ex_rd;
    assign mem_write   = r_mem_write;
    assign mem_store   = r_mem_store;
    assign mem_load    = r_mem_load;
    assign mem_rd      = r_mem_rd;
    assign wb_write    = r_wb_write;
    assign wb_load     = r_wb_load;
    assign wb_rd       = r_wb_rd;
    assign stall       = w_stall;
    assign flush_if_id = branch_taken;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: default instance plus a
// LOAD_USE_STALL=0 / REG_ADDR_W=4 instance driven from the same stimulus.
module tb_control_pipeline;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken;

    logic       ex_write, ex_store, ex_load, ex_branch, ex_b_sel, ex_illegal;
    logic [1:0] ex_a_sel, ex_npc_sel;
    logic [2:0] ex_imm_sel, ex_alu_sel;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_write, mem_store, mem_load, wb_write, wb_load;
    logic       stall, flush_if_id;

    logic       p_ex_write, p_ex_store, p_ex_load, p_ex_branch, p_ex_b_sel, p_ex_illegal;
    logic [1:0] p_ex_a_sel, p_ex_npc_sel;
    logic [2:0] p_ex_imm_sel, p_ex_alu_sel;
    logic [3:0] p_ex_rd, p_mem_rd, p_wb_rd;
    logic       p_mem_write, p_mem_store, p_mem_load, p_wb_write, p_wb_load;
    logic       p_stall, p_flush_if_id;

    control_pipeline u_dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .ex_write(ex_write), .ex_store(ex_store), .ex_load(ex_load), .ex_branch(ex_branch),
        .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel), .ex_imm_sel(ex_imm_sel),
        .ex_npc_sel(ex_npc_sel), .ex_alu_sel(ex_alu_sel), .ex_illegal(ex_illegal), .ex_rd(ex_rd),
        .mem_write(mem_write), .mem_store(mem_store), .mem_load(mem_load), .mem_rd(mem_rd),
        .wb_write(wb_write), .wb_load(wb_load), .wb_rd(wb_rd),
        .stall(stall), .flush_if_id(flush_if_id)
    );

    control_pipeline #(.ALU_SEL_W(3), .REG_ADDR_W(4), .LOAD_USE_STALL(0)) u_dut_p (
        .clk(clk), .rst(rst), .opcode(opcode),
        .id_rs1(id_rs1[3:0]), .id_rs2(id_rs2[3:0]), .id_rd(id_rd[3:0]), .branch_taken(branch_taken),
        .ex_write(p_ex_write), .ex_store(p_ex_store), .ex_load(p_ex_load), .ex_branch(p_ex_branch),
        .ex_a_sel(p_ex_a_sel), .ex_b_sel(p_ex_b_sel), .ex_imm_sel(p_ex_imm_sel),
        .ex_npc_sel(p_ex_npc_sel), .ex_alu_sel(p_ex_alu_sel), .ex_illegal(p_ex_illegal), .ex_rd(p_ex_rd),
        .mem_write(p_mem_write), .mem_store(p_mem_store), .mem_load(p_mem_load), .mem_rd(p_mem_rd),
        .wb_write(p_wb_write), .wb_load(p_wb_load), .wb_rd(p_wb_rd),
        .stall(p_stall), .flush_if_id(p_flush_if_id)
    );

    typedef struct packed {
        logic       write, store, load, branch;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [2:0] imm_sel;
        logic [1:0] npc_sel;
        logic [2:0] alu_sel;
        logic       illegal;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       write, store, load;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       write, load;
        logic [4:0] rd;
    } wb_t;

    localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, IA = 7'b0010011, JR = 7'b1100111;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, AU = 7'b0010111, LU = 7'b0110111;
    localparam logic [6:0] JL = 7'b1101111, BAD = 7'b0000000;

    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    ex_t  sb_q[$];
    ex_t  m_ex  = '0;
    mem_t m_mem = '0;
    wb_t  m_wb  = '0;
    logic m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    function automatic ex_t ref_decode(input logic [6:0] op, input logic [4:0] rd);
        ex_t e = '0;
        case (op)
            R:  begin e.write = 1; e.alu_sel = 3'd1; end
            LD: begin e.write = 1; e.load = 1; e.b_sel = 1; end
            IA: begin e.write = 1; e.b_sel = 1; e.alu_sel = 3'd1; end
            JR: begin e.write = 1; e.b_sel = 1; e.npc_sel = 2'b11; end
            ST: begin e.store = 1; e.b_sel = 1; e.imm_sel = 3'b001; end
            BR: begin e.branch = 1; e.imm_sel = 3'b010; e.npc_sel = 2'b01; end
            AU: begin e.write = 1; e.a_sel = 2'b01; e.b_sel = 1; e.imm_sel = 3'b011; end
            LU: begin e.write = 1; e.a_sel = 2'b10; e.b_sel = 1; e.imm_sel = 3'b011; end
            JL: begin e.write = 1; e.a_sel = 2'b01; e.b_sel = 1; e.imm_sel = 3'b100; e.npc_sel = 2'b10; end
            default: e.illegal = 1;
        endcase
        if (rd == 5'd0) e.write = 0;
        e.rd = rd;
        return e;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == R) || (op == LD) || (op == IA) || (op == JR) || (op == ST) || (op == BR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == R) || (op == ST) || (op == BR);
    endfunction

    // One cycle: drive ID inputs, check the combinational outputs, push the
    // expected ID/EX contents, then after the edge pop and compare all stages.
    task automatic step(input logic r, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic bt);
        ex_t        exp_ex;
        ex_t        got_ex;
        logic       exp_stall;
        logic [3:0] exp_p_rd;
        @(negedge clk);
        rst = r; opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; branch_taken = bt;
        step_no++;
        #1;
        exp_stall = m_ex.load && (m_ex.rd != 5'd0) && !bt &&
                    ((uses_rs1(op) && rs1 == m_ex.rd) || (uses_rs2(op) && rs2 == m_ex.rd));
        if (m_valid) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("p_stall", 32'(p_stall), 32'(1'b0));
        end
        check("flush", 32'(flush_if_id), 32'(bt));
        if (r || exp_stall || bt) exp_ex = '0;
        else                      exp_ex = ref_decode(op, rd);
        sb_q.push_back(exp_ex);
        exp_p_rd = (r || bt) ? 4'd0 : rd[3:0];

        @(posedge clk);
        #1;
        exp_ex = sb_q.pop_front();
        m_wb   = r ? '0 : '{write: m_mem.write, load: m_mem.load, rd: m_mem.rd};
        m_mem  = r ? '0 : '{write: m_ex.write, store: m_ex.store, load: m_ex.load, rd: m_ex.rd};
        m_ex   = exp_ex;
        m_valid = 1'b1;
        got_ex = '{write: ex_write, store: ex_store, load: ex_load, branch: ex_branch,
                   a_sel: ex_a_sel, b_sel: ex_b_sel, imm_sel: ex_imm_sel, npc_sel: ex_npc_sel,
                   alu_sel: ex_alu_sel, illegal: ex_illegal, rd: ex_rd};
        check("ex_bundle", 32'(got_ex), 32'(exp_ex));
        check("mem_stage", 32'({mem_write, mem_store, mem_load, mem_rd}), 32'(m_mem));
        check("wb_stage", 32'({wb_write, wb_load, wb_rd}), 32'(m_wb));
        check("p_ex_rd", 32'(p_ex_rd), 32'(exp_p_rd));
    endtask

    initial begin
        rst = 1'b1; opcode = R; id_rs1 = '0; id_rs2 = '0; id_rd = '0; branch_taken = 1'b0;

        // Reset held two cycles, then the first decoded R-type.
        step(1, R, 5'd2, 5'd3, 5'd1, 0);
        step(1, R, 5'd2, 5'd3, 5'd1, 0);
        step(0, R, 5'd2, 5'd3, 5'd1, 0);

        // Decode sweep, including an illegal opcode.
        step(0, R,   5'd1, 5'd2, 5'd10, 0);
        step(0, LD,  5'd1, 5'd2, 5'd10, 0);
        step(0, IA,  5'd1, 5'd2, 5'd10, 0);
        step(0, JR,  5'd1, 5'd2, 5'd10, 0);
        step(0, ST,  5'd1, 5'd2, 5'd10, 0);
        step(0, BR,  5'd1, 5'd2, 5'd10, 0);
        step(0, AU,  5'd1, 5'd2, 5'd10, 0);
        step(0, LU,  5'd1, 5'd2, 5'd10, 0);
        step(0, JL,  5'd1, 5'd2, 5'd10, 0);
        step(0, BAD, 5'd1, 5'd2, 5'd10, 0);

        // Load-use: one stall cycle, the held ADD then enters EX.
        step(0, LD, 5'd1, 5'd2, 5'd5, 0);
        step(0, R,  5'd5, 5'd2, 5'd6, 0);
        step(0, R,  5'd5, 5'd2, 5'd6, 0);
        // Load to x0 never stalls.
        step(0, LD, 5'd1, 5'd2, 5'd0, 0);
        step(0, R,  5'd0, 5'd0, 5'd6, 0);

        // Taken branch beats the load-use stall.
        step(0, LD, 5'd1, 5'd2, 5'd3, 0);
        step(0, R,  5'd3, 5'd2, 5'd4, 1);
        step(0, IA, 5'd1, 5'd2, 5'd2, 0);

        // Load walks EX -> MEM -> WB.
        step(0, LD, 5'd1, 5'd2, 5'd7, 0);
        step(0, IA, 5'd1, 5'd2, 5'd8, 0);
        step(0, IA, 5'd1, 5'd2, 5'd8, 0);
        check("walk_wb_load", 32'(wb_load), 32'(1'b1));
        check("walk_wb_rd", 32'(wb_rd), 32'(5'd7));
        check("walk_wb_write", 32'(wb_write), 32'(1'b1));

        // rd wraps in the 4-bit instance.
        step(0, R, 5'd1, 5'd2, 5'd21, 0);
        check("wrap_p_ex_rd", 32'(p_ex_rd), 32'(4'd5));

        // Mid-stream reset.
        step(0, LD, 5'd1, 5'd2, 5'd9, 0);
        step(1, R,  5'd1, 5'd2, 5'd1, 0);
        step(0, R,  5'd1, 5'd2, 5'd1, 0);
        step(0, IA, 5'd1, 5'd2, 5'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
